// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, default latencies,
// sequencer states and the arithmetic result bundle.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE,
        RUN
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        divByZero;
    } mdu_result_t;

    function automatic logic isMdOp(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic isMultOp(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU signal bundle; master is the pipeline side, slave is the MDU.
interface mdu_ctrl_if;

    logic [3:0]  MDU_Ctrl;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Req;
    logic        Start;
    logic        Busy;
    logic        Stall_MD;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MD_res;

    modport master (
        output MDU_Ctrl, SrcA, SrcB, Req,
        input  Start, Busy, Stall_MD, HI, LO, MD_res
    );

    modport slave (
        input  MDU_Ctrl, SrcA, SrcB, Req,
        output Start, Busy, Stall_MD, HI, LO, MD_res
    );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational 32x32 multiply/divide producing the full HI/LO result for one op.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output mdu_result_t res
);

    logic [63:0] prodS;
    logic [63:0] prodU;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] divisorU;
    logic [31:0] divisorS;
    logic [31:0] qU;
    logic [31:0] rU;
    logic [31:0] qM;
    logic [31:0] rM;

    assign prodU = {32'b0, srcA} * {32'b0, srcB};
    assign prodS = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign magA     = srcA[31] ? -srcA : srcA;
    assign magB     = srcB[31] ? -srcB : srcB;
    assign divisorU = (srcB == '0) ? 32'd1 : srcB;
    assign divisorS = (magB == '0) ? 32'd1 : magB;
    assign qU       = srcA / divisorU;
    assign rU       = srcA % divisorU;
    assign qM       = magA / divisorS;
    assign rM       = magA % divisorS;

    always_comb begin
        res = '0;
        case (op)
            MDU_MULT: begin
                res.hi = prodS[63:32];
                res.lo = prodS[31:0];
            end
            MDU_MULTU: begin
                res.hi = prodU[63:32];
                res.lo = prodU[31:0];
            end
            MDU_DIV: begin
                res.divByZero = (srcB == '0);
                res.lo        = (srcA[31] ^ srcB[31]) ? -qM : qM;
                res.hi        = srcA[31] ? -rM : rM;
            end
            MDU_DIVU: begin
                res.divByZero = (srcB == '0);
                res.lo        = qU;
                res.hi        = rU;
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, holds a latched result for a fixed
// latency, then commits it; also serves mthi/mtlo/mfhi/mflo.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e  state;
    mdu_state_e  nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nextCnt;
    logic        commit;
    logic        busy;
    logic        start;
    logic        writeHi;
    logic        writeLo;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [31:0] pendHi;
    logic [31:0] pendLo;
    logic        pendDbz;
    mdu_result_t arithRes;

    mdu_arith uArith (
        .op   (bus.MDU_Ctrl),
        .srcA (bus.SrcA),
        .srcB (bus.SrcB),
        .res  (arithRes)
    );

    assign busy    = (state == RUN);
    assign start   = isMdOp(bus.MDU_Ctrl) && !bus.Req && !busy;
    assign writeHi = (bus.MDU_Ctrl == MDU_MTHI) && !bus.Req && !busy;
    assign writeLo = (bus.MDU_Ctrl == MDU_MTLO) && !bus.Req && !busy;

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                    nextCnt   = isMultOp(bus.MDU_Ctrl) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                end
            end
            RUN: begin
                nextCnt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    commit    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendHi  <= '0;
            pendLo  <= '0;
            pendDbz <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            if (start) begin
                pendHi  <= arithRes.hi;
                pendLo  <= arithRes.lo;
                pendDbz <= arithRes.divByZero;
            end
            // Divide-by-zero still runs the full latency but leaves HI/LO alone.
            if (commit && !pendDbz) begin
                hiReg <= pendHi;
                loReg <= pendLo;
            end else begin
                if (writeHi) hiReg <= bus.SrcA;
                if (writeLo) loReg <= bus.SrcA;
            end
        end
    end

    always_comb begin
        case (bus.MDU_Ctrl)
            MDU_MFHI: bus.MD_res = hiReg;
            MDU_MFLO: bus.MD_res = loReg;
            default:  bus.MD_res = '0;
        endcase
    end

    assign bus.Start    = start;
    assign bus.Busy     = busy;
    assign bus.Stall_MD = start || busy;
    assign bus.HI       = hiReg;
    assign bus.LO       = loReg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed cases plus randomized ops against a
// plain-arithmetic HI/LO model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned len;
    } commit_t;

    commit_t     commitQ[$];
    logic [31:0] readQ[$];
    int          checks = 0;
    int          errors = 0;
    int          issuedCnt = 0;
    int          startSeen = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic straight from the ISA rules.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        logic signed [31:0] sa, sb;
        longint             p;
        logic [63:0]        pu;
        sa = a; sb = b; hi = mHi; lo = mLo;
        case (op)
            4'd1: begin p = longint'(sa) * longint'(sb); hi = p[63:32]; lo = p[31:0]; end
            4'd2: begin pu = 64'(a) * 64'(b); hi = pu[63:32]; lo = pu[31:0]; end
            4'd3: begin
                if (b == 32'd0) begin end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 32'd0; end
                else begin lo = sa / sb; hi = sa % sb; end
            end
            4'd4: if (b != 32'd0) begin lo = a / b; hi = a % b; end
            default: ;
        endcase
    endtask

    // Monitor: commits checked when Busy falls, reads checked when mfhi/mflo is presented.
    int      busyRun = 0;
    logic    prevBusy = 1'b0;
    commit_t cur;
    always @(negedge clk) begin
        if (reset) begin
            busyRun  = 0;
            prevBusy = 1'b0;
        end else begin
            if (bus.Start) startSeen++;
            if (bus.Busy) busyRun++;
            else if (prevBusy) begin
                if (commitQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL commitQ: got a commit, expected none pending");
                end else begin
                    cur = commitQ.pop_front();
                    check("commitHI", bus.HI, cur.hi);
                    check("commitLO", bus.LO, cur.lo);
                    check("busyLen", 32'(busyRun), 32'(cur.len));
                end
                busyRun = 0;
            end
            if ((bus.MDU_Ctrl == 4'd7 || bus.MDU_Ctrl == 4'd8) && !bus.Req && !bus.Busy) begin
                if (readQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL readQ: got a read, expected none pending");
                end else check("MD_res", bus.MD_res, readQ.pop_front());
            end
            prevBusy = bus.Busy;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic waitIdle;
        int n = 0;
        while (bus.Busy && n < 200) begin tick(); n++; end
        if (bus.Busy) begin
            checks++; errors++;
            $display("FAIL waitIdle: got Busy=1 after 200 cycles, expected 0");
        end
    endtask

    // Drives one op for one cycle (called just after a rising edge).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
        logic        expStart;
        logic [31:0] hi, lo;
        bus.MDU_Ctrl = op; bus.SrcA = a; bus.SrcB = b; bus.Req = req;
        expStart = (op >= 4'd1 && op <= 4'd4) && !req && !bus.Busy;
        if (expStart) begin
            model(op, a, b, hi, lo);
            mHi = hi; mLo = lo;
            issuedCnt++;
            commitQ.push_back('{hi: hi, lo: lo, len: (op <= 4'd2) ? MC : DC});
        end else if (!req && !bus.Busy) begin
            if (op == 4'd5) mHi = a;
            if (op == 4'd6) mLo = a;
            if (op == 4'd7) readQ.push_back(mHi);
            if (op == 4'd8) readQ.push_back(mLo);
        end
        @(negedge clk);
        check("Start", {31'b0, bus.Start}, {31'b0, expStart});
        check("Stall_MD", {31'b0, bus.Stall_MD}, {31'b0, expStart || bus.Busy});
        tick();
        bus.MDU_Ctrl = 4'd0; bus.Req = 1'b0;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    int st;

    initial begin
        reset = 1'b1;
        bus.MDU_Ctrl = 4'd0; bus.SrcA = '0; bus.SrcB = '0; bus.Req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstHI", bus.HI, 32'd0);
        check("rstLO", bus.LO, 32'd0);
        check("rstBusy", {31'b0, bus.Busy}, 32'd0);
        reset = 1'b0;
        tick();

        // mult -2 x 3, including the Stall_MD window
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        st = 1;
        while (bus.Stall_MD && st < 50) begin st++; tick(); end
        check("stallCycles", 32'(st), 32'd6);
        check("multHI", bus.HI, 32'hFFFF_FFFF);
        check("multLO", bus.LO, 32'hFFFF_FFFA);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0); waitIdle();
        check("multuHI", bus.HI, 32'h0000_0001);
        check("multuLO", bus.LO, 32'hFFFF_FFFE);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0); waitIdle();
        check("divHI", bus.HI, 32'hFFFF_FFFF);
        check("divLO", bus.LO, 32'hFFFF_FFFD);
        issue(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0); waitIdle();
        check("divuHI", bus.HI, 32'h0000_0001);
        check("divuLO", bus.LO, 32'h7FFF_FFFC);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0); waitIdle();
        check("ovfHI", bus.HI, 32'd0);
        check("ovfLO", bus.LO, 32'h8000_0000);

        // divide by zero keeps the preloaded registers
        issue(4'd5, 32'h1234, 32'd0, 1'b0);
        issue(4'd6, 32'h5678, 32'd0, 1'b0);
        issue(4'd4, 32'd99, 32'd0, 1'b0); waitIdle();
        check("dbzHI", bus.HI, 32'h1234);
        check("dbzLO", bus.LO, 32'h5678);
        issue(4'd7, 32'd0, 32'd0, 1'b0);

        // flushed issue, then reset mid-operation
        issue(4'd1, 32'd3, 32'd4, 1'b1);
        check("reqBusy", {31'b0, bus.Busy}, 32'd0);
        check("reqLO", bus.LO, 32'h5678);
        issue(4'd1, 32'd3, 32'd4, 1'b0);
        tick();
        reset = 1'b1;
        commitQ.delete();
        mHi = '0; mLo = '0;
        #1;
        check("midRstBusy", {31'b0, bus.Busy}, 32'd0);
        check("midRstHI", bus.HI, 32'd0);
        check("midRstLO", bus.LO, 32'd0);
        tick();
        reset = 1'b0;
        repeat (12) tick();
        check("postRstLO", bus.LO, 32'd0);
        issue(4'd8, 32'd0, 32'd0, 1'b0);

        // ops held during Busy are ignored; back-to-back issue when Busy falls
        issue(4'd1, 32'd2, 32'd3, 1'b0);
        issue(4'd1, 32'd7, 32'd7, 1'b0);
        issue(4'd6, 32'hAA, 32'd0, 1'b0);
        waitIdle();
        check("holdLO", bus.LO, 32'd6);
        issue(4'd3, 32'd100, 32'd7, 1'b0);
        check("b2bBusy", {31'b0, bus.Busy}, 32'd1);
        waitIdle();

        for (int i = 0; i < 150; i++) begin
            waitIdle();
            issue(4'($urandom_range(1, 8)), pickOperand(), pickOperand(), ($urandom_range(0, 7) == 0));
        end
        waitIdle();
        tick();
        check("startCount", 32'(startSeen), 32'(issuedCnt));
        check("queuesEmpty", 32'(commitQ.size() + readQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
